// File: rtl/fifo_sync_fwft_pkg.sv
// Shared sizing helpers for the FWFT FIFO and its RAM.
package fifo_sync_fwft_pkg;

   // Address width of a DEPTH-entry RAM (DEPTH is a power of two).
   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

   // Width able to hold an occupancy of 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered synchronous read port.
module fifo_sdp_ram
   import fifo_sync_fwft_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 512
) (
   input  logic                    clk,
   input  logic                    we_i,
   input  logic [ptr_w(DEPTH)-1:0] waddr_i,
   input  logic [WIDTH-1:0]        wdata_i,
   input  logic                    re_i,
   input  logic [ptr_w(DEPTH)-1:0] raddr_i,
   output logic [WIDTH-1:0]        rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // Write port.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   // Read port; the data register holds whenever no read is issued.
   always_ff @(posedge clk) begin
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_sync_fwft.sv
// Single-clock first-word-fall-through FIFO. The RAM read register is the
// output register, so the head entry is held in it and counts toward DEPTH.
module fifo_sync_fwft
   import fifo_sync_fwft_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int DEPTH      = 512,
   parameter int AFULL_LVL  = DEPTH - 4,
   parameter int AEMPTY_LVL = 2
) (
   input  logic                    clk,
   input  logic                    srst_n,
   input  logic                    flush,
   input  logic                    i_val,
   output logic                    i_rdy,
   input  logic [WIDTH-1:0]        i_data,
   output logic                    o_val,
   input  logic                    o_rdy,
   output logic [WIDTH-1:0]        o_data,
   output logic [cnt_w(DEPTH)-1:0] o_count,
   output logic                    o_afull,
   output logic                    o_aempty
);

   localparam int CW = cnt_w(DEPTH);
   localparam int PW = ptr_w(DEPTH);
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LVL);
   localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LVL);

   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] ram_cnt_q, ram_cnt_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic          o_val_q, o_val_d;
   logic          afull_q, afull_d;
   logic          aempty_q, aempty_d;
   logic          push, pop, rden, active;

   // Acceptance depends only on the current count: no pass-through when full.
   assign i_rdy  = (count_q < DEPTH_C) && !flush;
   assign active = srst_n && !flush;

   // Next-state for pointers, occupancies, head valid and level flags.
   always_comb begin
      push      = i_val && i_rdy && srst_n;
      pop       = o_val_q && o_rdy;
      rden      = active && (ram_cnt_q != '0) && (!o_val_q || o_rdy);
      wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d  = rden ? rd_ptr_q + PW'(1) : rd_ptr_q;
      ram_cnt_d = ram_cnt_q + CW'(push) - CW'(rden);
      count_d   = count_q + CW'(push) - CW'(pop);
      o_val_d   = o_val_q;
      if (rden)     o_val_d = 1'b1;
      else if (pop) o_val_d = 1'b0;
      afull_d   = (count_d >= AFULL_C);
      aempty_d  = (count_d <= AEMPTY_C);
   end

   // State registers; reset wins over flush, both return to empty.
   always_ff @(posedge clk) begin
      if (!srst_n || flush) begin
         count_q   <= '0;
         ram_cnt_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         o_val_q   <= 1'b0;
         afull_q   <= 1'b0;
         aempty_q  <= 1'b1;
      end else begin
         count_q   <= count_d;
         ram_cnt_q <= ram_cnt_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         o_val_q   <= o_val_d;
         afull_q   <= afull_d;
         aempty_q  <= aempty_d;
      end
   end

   fifo_sdp_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk     (clk),
      .we_i    (push),
      .waddr_i (wr_ptr_q),
      .wdata_i (i_data),
      .re_i    (rden),
      .raddr_i (rd_ptr_q),
      .rdata_o (o_data)
   );

   assign o_val    = o_val_q;
   assign o_count  = count_q;
   assign o_afull  = afull_q;
   assign o_aempty = aempty_q;

endmodule

// File: tb/tb_fifo_sync_fwft.sv
// Bench for fifo_sync_fwft: directed table, corner sequences, random soak.
module tb_fifo_sync_fwft;

   localparam int W  = 40;
   localparam int D  = 16;
   localparam int AF = 12;
   localparam int AE = 2;

   logic          clk = 1'b0;
   logic          srst_n, flush, i_val, i_rdy, o_val, o_rdy, o_afull, o_aempty;
   logic [W-1:0]  i_data, o_data;
   logic [4:0]    o_count;

   fifo_sync_fwft #(.WIDTH(W), .DEPTH(D), .AFULL_LVL(AF), .AEMPTY_LVL(AE)) dut (
      .clk(clk), .srst_n(srst_n), .flush(flush), .i_val(i_val), .i_rdy(i_rdy),
      .i_data(i_data), .o_val(o_val), .o_rdy(o_rdy), .o_data(o_data),
      .o_count(o_count), .o_afull(o_afull), .o_aempty(o_aempty)
   );

   always #5 clk = ~clk;

   // Reference: ordered list of entries tagged with the edge that wrote them.
   // An entry is presented once it is at the head and was written at an
   // earlier edge than the most recent one (one cycle of read latency).
   typedef struct { logic [W-1:0] d; int t; } ent_t;
   ent_t mq[$];
   int   cyc = 0;
   int   n_chk = 0, n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @edge %0d: got %0h expected %0h", name, cyc, act, exp);
   endtask

   function automatic bit m_vis();
      return (mq.size() > 0) && (mq[0].t < cyc);
   endfunction

   // Advance one edge with the inputs currently driven, then compare.
   task automatic tick();
      int sz;
      sz = mq.size();
      if (!srst_n || flush) mq.delete();
      else begin
         if (m_vis() && o_rdy) void'(mq.pop_front());
         if (i_val && sz < D) mq.push_back('{i_data, cyc + 1});
      end
      @(posedge clk);
      cyc++;
      #1;
      chk("o_val", 64'(o_val), 64'(m_vis()));
      chk("o_count", 64'(o_count), 64'(mq.size()));
      chk("o_afull", 64'(o_afull), 64'(mq.size() >= AF));
      chk("o_aempty", 64'(o_aempty), 64'(mq.size() <= AE));
      chk("i_rdy", 64'(i_rdy), 64'(mq.size() < D && !flush));
      if (m_vis()) chk("o_data", 64'(o_data), 64'(mq[0].d));
   endtask

   task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy);
      i_val = iv; i_data = d; o_rdy = ordy;
   endtask

   typedef struct {
      logic iv; logic [W-1:0] d; logic ordy;
      logic ev; logic [4:0] ecnt; logic [W-1:0] ed; logic eae;
   } vec_t;
   vec_t tv[7];

   initial begin
      // Latency, stall, and in-order pop with hand-derived expectations.
      tv[0] = '{1'b1, 40'hA5, 1'b0, 1'b0, 5'd1, 40'h0,  1'b1};
      tv[1] = '{1'b0, 40'h0,  1'b0, 1'b1, 5'd1, 40'hA5, 1'b1};
      tv[2] = '{1'b1, 40'h11, 1'b0, 1'b1, 5'd2, 40'hA5, 1'b1};
      tv[3] = '{1'b1, 40'h22, 1'b0, 1'b1, 5'd3, 40'hA5, 1'b0};
      tv[4] = '{1'b0, 40'h0,  1'b1, 1'b1, 5'd2, 40'h11, 1'b1};
      tv[5] = '{1'b0, 40'h0,  1'b1, 1'b1, 5'd1, 40'h22, 1'b1};
      tv[6] = '{1'b0, 40'h0,  1'b1, 1'b0, 5'd0, 40'h0,  1'b1};

      srst_n = 1'b0; flush = 1'b0; drive(1'b0, '0, 1'b0);
      tick(); tick();
      chk("rst_o_val", 64'(o_val), 64'd0);
      chk("rst_o_count", 64'(o_count), 64'd0);
      chk("rst_o_aempty", 64'(o_aempty), 64'd1);
      chk("rst_o_afull", 64'(o_afull), 64'd0);
      srst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         drive(tv[i].iv, tv[i].d, tv[i].ordy);
         tick();
         chk($sformatf("tv%0d_val", i), 64'(o_val), 64'(tv[i].ev));
         chk($sformatf("tv%0d_cnt", i), 64'(o_count), 64'(tv[i].ecnt));
         chk($sformatf("tv%0d_ae", i), 64'(o_aempty), 64'(tv[i].eae));
         if (tv[i].ev) chk($sformatf("tv%0d_data", i), 64'(o_data), 64'(tv[i].ed));
      end

      // Stall stability: 3 queued, consumer stalled for 5 cycles.
      for (int i = 0; i < 3; i++) begin drive(1'b1, 40'h30 + W'(i), 1'b0); tick(); end
      drive(1'b0, '0, 1'b0);
      tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_data", 64'(o_data), 64'h30);
         chk("stall_cnt", 64'(o_count), 64'd3);
      end
      o_rdy = 1'b1; tick();
      chk("stall_next", 64'(o_data), 64'h31);
      tick(); tick(); o_rdy = 1'b0; tick();

      // Fill with consumer stalled; 17th write must be refused.
      for (int i = 0; i < 17; i++) begin drive(1'b1, W'(i), 1'b0); tick(); end
      chk("full_cnt", 64'(o_count), 64'd16);
      chk("full_irdy", 64'(i_rdy), 64'd0);
      chk("full_afull", 64'(o_afull), 64'd1);

      // Full with concurrent pop: write refused, pop taken; next write lands.
      drive(1'b1, 40'hEE, 1'b1); tick();
      chk("fullpop_cnt", 64'(o_count), 64'd15);
      chk("fullpop_head", 64'(o_data), 64'd1);
      drive(1'b1, 40'hEE, 1'b0); tick();
      chk("refill_cnt", 64'(o_count), 64'd16);

      // Drain: 16 consecutive pops, no bubbles, then empty.
      drive(1'b0, '0, 1'b1);
      for (int i = 0; i < 16; i++) begin
         chk("drain_val", 64'(o_val), 64'd1);
         chk("drain_data", 64'(o_data), (i < 15) ? 64'(i + 1) : 64'hEE);
         tick();
      end
      chk("drain_empty", 64'(o_val), 64'd0);

      // Flush, then reset, with 9 entries and a write in the same cycle.
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < 9; i++) begin drive(1'b1, 40'h90 + W'(i), 1'b0); tick(); end
         drive(1'b1, 40'hBAD, 1'b0);
         if (pass == 0) flush = 1'b1; else srst_n = 1'b0;
         tick();
         flush = 1'b0; srst_n = 1'b1;
         chk("clr_val", 64'(o_val), 64'd0);
         chk("clr_cnt", 64'(o_count), 64'd0);
         chk("clr_ae", 64'(o_aempty), 64'd1);
         drive(1'b1, 40'h77 + W'(pass), 1'b0); tick();
         drive(1'b0, '0, 1'b0); tick();
         chk("clr_fresh", 64'(o_data), 64'h77 + 64'(pass));
         o_rdy = 1'b1; tick(); o_rdy = 1'b0;
      end

      // Random soak with varying fill bias and rare flushes.
      for (int i = 0; i < 3000; i++) begin
         int bias;
         bias = ((i / 300) % 3) + 1;
         i_val  = ($urandom_range(0, 3) < bias);
         o_rdy  = ($urandom_range(0, 3) >= bias);
         i_data = {8'($urandom), 32'($urandom)};
         flush  = ($urandom_range(0, 199) == 0);
         tick();
      end
      flush = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
